// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The DMEM_BYTE_STROBE_EN build option is handled in dmem_responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W     = 64;
    localparam int BYTE_OFF_W = 3;

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous doubleword RAM with per-byte write enables.
// Only the read-data register is reset; the storage array keeps its contents.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = index_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [7:0]        strb,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data only moves on a load, so it holds between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder in front of dmem_array.
// Define DMEM_BYTE_STROBE_EN to add the wstrb byte-strobe input.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic [WORD_W-1:0] WriteData,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [7:0]        wstrb,
`endif
    output logic              ready,
    output logic [WORD_W-1:0] read_mem_data,
    output logic              rvalid,
    output logic              wack,
    output logic              err
);

    localparam int IDX_W = index_width(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  data_q;
    logic               err_q;

    logic               accept;
    logic               req_err;
    logic               do_access;
    logic               align_ok;
    logic [2:0]         addr_off;
    logic [IDX_W-1:0]   in_idx;

    logic               arr_en;
    logic               arr_we;
    logic [7:0]         arr_strb;
    logic [IDX_W-1:0]   arr_idx;
    logic [WORD_W-1:0]  arr_wdata;

    assign addr_off = Mem_Addr[2:0];
    assign in_idx   = Mem_Addr[BYTE_OFF_W +: IDX_W];

    generate
        if (ADDR_W > BYTE_OFF_W + IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^Mem_Addr[ADDR_W-1:BYTE_OFF_W+IDX_W];
        end
    endgenerate

`ifdef DMEM_BYTE_STROBE_EN
    logic [7:0] strb_q;

    // Legal strobes are contiguous, naturally aligned runs of 1, 2, 4 or 8 bytes.
    function automatic logic strobe_legal(input logic [7:0] s, input logic [2:0] off);
        case (s)
            8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
            8'h10, 8'h20, 8'h40, 8'h80:       return 1'b1;
            8'h03, 8'h0C, 8'h30, 8'hC0:       return (off[0] == 1'b0);
            8'h0F, 8'hF0:                     return (off[1:0] == 2'b00);
            8'hFF:                            return (off == 3'b000);
            default:                          return 1'b0;
        endcase
    endfunction

    assign align_ok = MemWrite ? strobe_legal(wstrb, addr_off) : (addr_off == 3'b000);
    assign arr_strb = (state == IDLE) ? wstrb : strb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_q <= '0;
        end else if (accept) begin
            strb_q <= wstrb;
        end
    end
`else
    assign align_ok = (addr_off == 3'b000);
    assign arr_strb = 8'hFF;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err_q <= req_err;
            if (accept) begin
                write_q <= MemWrite;
                idx_q   <= in_idx;
                data_q  <= WriteData;
            end
        end
    end

    // The array access happens on the edge that enters RESP, so RESP is the response cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        req_err    = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead && MemWrite) begin
                    req_err = 1'b1;
                end else if (MemRead || MemWrite) begin
                    if (!align_ok) begin
                        req_err = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        cnt_next = CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            do_access  = 1'b1;
                            state_next = RESP;
                        end else begin
                            state_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Gating with reset keeps a pending store from committing on the reset edge.
    assign arr_en    = do_access && !reset;
    assign arr_we    = (state == IDLE) ? MemWrite  : write_q;
    assign arr_idx   = (state == IDLE) ? in_idx    : idx_q;
    assign arr_wdata = (state == IDLE) ? WriteData : data_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (arr_en),
        .we    (arr_we),
        .strb  (arr_strb),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (read_mem_data)
    );

    assign ready  = (state == IDLE);
    assign rvalid = (state == RESP) && !write_q;
    assign wack   = (state == RESP) &&  write_q;
    assign err    = err_q;

endmodule
